// File: rtl/lsr_pkg.sv
// Shared types and the lane shift helper for lane_shift_right_pipe.
package lsr_pkg;

  localparam int LANE_W    = 5;
  localparam int LANES     = 10;
  localparam int SHIFT_W   = 3;
  localparam int MAX_SHIFT = 4;
  localparam int ERRCNT_W  = 8;
  localparam int DATA_W    = LANE_W * LANES;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    logic  rot;
    logic  err;
    logic  lo;
    lane_t fill;
    word_t word;
  } s1_t;

  typedef struct packed {
    logic  err;
    word_t word;
  } s2_t;

  // Output lane j takes input lane j+n; past the top it wraps (rot) or takes fill.
  // Constant-index selects only, so the mux tree stays shallow and warning-free.
  function automatic word_t lane_shr(input word_t word, input lane_t fill,
                                     input logic [SHIFT_W-1:0] n, input logic rot);
    word_t res;
    lane_t ln;
    res = '0;
    for (int j = 0; j < LANES; j++) begin
      ln = fill;
      for (int k = 0; k < LANES; k++) begin
        if (j + int'(n) == k) ln = word[k*LANE_W +: LANE_W];
        if (rot && (j + int'(n) == k + LANES)) ln = word[k*LANE_W +: LANE_W];
      end
      res[j*LANE_W +: LANE_W] = ln;
    end
    return res;
  endfunction

endpackage

// File: rtl/lsr_stage.sv
// One valid/ready register slice; loads whenever empty or its downstream is accepting.
module lsr_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  logic         v_q, v_d;
  logic [W-1:0] data_q, data_d;
  logic         load;

  always_comb begin
    load   = !v_q || dn_ready;
    v_d    = load ? up_valid : v_q;
    data_d = (load && up_valid) ? up_data : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign up_ready = load;
  assign dn_valid = v_q;
  assign dn_data  = data_q;

endmodule

// File: rtl/lane_shift_right_pipe.sv
// Two-stage lane right shifter (coarse even shift, then fine 1-lane shift) with error counter.
// Optional rotate mode and in_rot port enabled by defining LSR_ROTATE_EN.
module lane_shift_right_pipe #(
  parameter int LANE_W    = lsr_pkg::LANE_W,
  parameter int LANES     = lsr_pkg::LANES,
  parameter int SHIFT_W   = lsr_pkg::SHIFT_W,
  parameter int MAX_SHIFT = lsr_pkg::MAX_SHIFT,
  parameter int ERRCNT_W  = lsr_pkg::ERRCNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*LANE_W-1:0]  in_data,
  input  logic [SHIFT_W-1:0]       in_shift,
  input  logic [LANE_W-1:0]        in_fill,
`ifdef LSR_ROTATE_EN
  input  logic                     in_rot,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*LANE_W-1:0]  out_data,
  output logic                     out_err,
  output logic [ERRCNT_W-1:0]      err_cnt
);
  import lsr_pkg::*;

  logic                rot_i;
  logic                legal;
  logic [SHIFT_W-1:0]  coarse_n;
  s1_t                 s1_in, s1_out;
  s2_t                 s2_in, s2_out;
  logic                s1_v, s1_dn_ready;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

`ifdef LSR_ROTATE_EN
  assign rot_i = in_rot;
`else
  assign rot_i = 1'b0;
`endif

  // Illegal shifts become an all-fill word up front with lo cleared, so S2 passes it untouched.
  always_comb begin
    legal      = (in_shift <= SHIFT_W'(MAX_SHIFT));
    coarse_n   = in_shift & ~SHIFT_W'(1);
    s1_in.rot  = rot_i;
    s1_in.err  = !legal;
    s1_in.lo   = legal & in_shift[0];
    s1_in.fill = in_fill;
    s1_in.word = legal ? lane_shr(in_data, in_fill, coarse_n, rot_i) : {LANES{in_fill}};
  end

  always_comb begin
    s2_in.err  = s1_out.err;
    s2_in.word = lane_shr(s1_out.word, s1_out.fill, {{(SHIFT_W-1){1'b0}}, s1_out.lo}, s1_out.rot);
  end

  lsr_stage #(.W($bits(s1_t))) u_s1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (in_valid),
    .up_ready (in_ready),
    .up_data  (s1_in),
    .dn_valid (s1_v),
    .dn_ready (s1_dn_ready),
    .dn_data  (s1_out)
  );

  lsr_stage #(.W($bits(s2_t))) u_s2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (s1_v),
    .up_ready (s1_dn_ready),
    .up_data  (s2_in),
    .dn_valid (out_valid),
    .dn_ready (out_ready),
    .dn_data  (s2_out)
  );

  // Counted as the word leaves S1; saturates at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s1_v && s1_dn_ready && s1_out.err && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign out_data = s2_out.word;
  assign out_err  = s2_out.err;
  assign err_cnt  = err_cnt_q;

endmodule
